// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encodings, error-code bit positions and timeout default.
// Used by the receiver and available to the transmitter and the mouse master FSM.
package ps2_pkg;

    typedef enum logic [2:0] {
        RX_IDLE        = 3'd0,
        RX_READ_DATA   = 3'd1,
        RX_READ_PARITY = 3'd2,
        RX_READ_STOP   = 3'd3,
        RX_DONE        = 3'd4
    } rx_state_e;

    localparam int ERR_PARITY = 0;
    localparam int ERR_STOP   = 1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

    // Odd parity over data plus parity bit: an even number of ones is an error.
    function automatic logic odd_parity_err(input logic [7:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/mouse_receiver_if.sv
// Receiver-facing bundle: raw PS/2 lines and READ_ENABLE in; byte, strobe, error code and state out.
// The slave side is the receiver; the master side is the mouse master FSM (or a bench).
interface mouse_receiver_if;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       READ_ENABLE;
    logic       BYTE_READ;
    logic [7:0] BYTE;
    logic [1:0] BYTE_ERROR_CODE;
    logic [2:0] STATE;

    modport slave (
        input  CLK_MOUSE_IN,
        input  DATA_MOUSE_IN,
        input  READ_ENABLE,
        output BYTE_READ,
        output BYTE,
        output BYTE_ERROR_CODE,
        output STATE
    );

    modport master (
        output CLK_MOUSE_IN,
        output DATA_MOUSE_IN,
        output READ_ENABLE,
        input  BYTE_READ,
        input  BYTE,
        input  BYTE_ERROR_CODE,
        input  STATE
    );
endinterface

// File: rtl/ps2_line_sync.sv
// 2-flop synchroniser for a PS/2 clock/data pair plus falling-edge detect on the clock line.
// Edge appears 2-3 cycles after the raw transition; no backpressure.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic fall_o
);

    logic clk_meta_q;
    logic clk_sync_q;
    logic clk_prev_q;
    logic data_meta_q;
    logic data_sync_q;

    // Reset to 1 so an idle (high) bus never produces a spurious edge after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_sync_o  = clk_sync_q;
    assign data_sync_o = data_sync_q;
    assign fall_o      = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host frame receiver; BYTE_READ strobes 1 CLK after the stop-bit edge is detected.
// No backpressure: a strobe the consumer misses is lost; errored frames are still delivered.
module mouse_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    mouse_receiver_if.slave  rx
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic clk_sync;
    logic data_sync;
    logic fall;
    logic edge_seen;

    ps2_line_sync u_sync (
        .clk_i       (CLK),
        .rst_n_i     (RESET),
        .ps2_clk_i   (rx.CLK_MOUSE_IN),
        .ps2_data_i  (rx.DATA_MOUSE_IN),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .fall_o      (fall)
    );

    assign edge_seen = fall & ~clk_sync;

    rx_state_e   state_q,     state_d;
    logic [7:0]  shift_q,     shift_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [15:0] to_cnt_q,    to_cnt_d;
    logic        par_err_q,   par_err_d;
    logic [7:0]  byte_q,      byte_d;
    logic [1:0]  err_q,       err_d;
    logic        byte_read_q, byte_read_d;
    logic        timed_out;

    assign timed_out = (to_cnt_q >= TIMEOUT_LIM);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_err_d   = par_err_q;
        byte_d      = byte_q;
        err_d       = err_q;
        byte_read_d = 1'b0;
        to_cnt_d    = edge_seen ? 16'd0 : to_cnt_q + 16'd1;

        // In states 1-3 an edge always takes priority over an expiring timeout.
        case (state_q)
            RX_IDLE: begin
                to_cnt_d = 16'd0;
                if (edge_seen && rx.READ_ENABLE && !data_sync) begin
                    state_d   = RX_READ_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            RX_READ_DATA: begin
                if (edge_seen) begin
                    shift_d[bit_cnt_q] = data_sync;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_READ_PARITY;
                    end
                end else if (timed_out) begin
                    state_d = RX_IDLE;
                end
            end
            RX_READ_PARITY: begin
                if (edge_seen) begin
                    par_err_d = odd_parity_err(shift_q, data_sync);
                    state_d   = RX_READ_STOP;
                end else if (timed_out) begin
                    state_d = RX_IDLE;
                end
            end
            RX_READ_STOP: begin
                if (edge_seen) begin
                    byte_d             = shift_q;
                    err_d[ERR_STOP]    = ~data_sync;
                    err_d[ERR_PARITY]  = par_err_q;
                    byte_read_d        = 1'b1;
                    state_d            = RX_DONE;
                end else if (timed_out) begin
                    state_d = RX_IDLE;
                end
            end
            RX_DONE: begin
                state_d = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= RX_IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            to_cnt_q    <= 16'd0;
            par_err_q   <= 1'b0;
            byte_q      <= 8'h00;
            err_q       <= 2'b00;
            byte_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            par_err_q   <= par_err_d;
            byte_q      <= byte_d;
            err_q       <= err_d;
            byte_read_q <= byte_read_d;
        end
    end

    assign rx.BYTE_READ       = byte_read_q;
    assign rx.BYTE            = byte_q;
    assign rx.BYTE_ERROR_CODE = err_q;
    assign rx.STATE           = state_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// Bench for mouse_receiver: a PS/2 device model drives frames; a frame-level model predicts byte and error code.
module tb_mouse_receiver;

    localparam int HALF_MCLK = 400;   // 40 CLK cycles per mouse bit keeps the run short
    localparam int QTR_MCLK  = 200;

    logic clk;
    logic rst_n;

    mouse_receiver_if ifc ();

    mouse_receiver #(.TIMEOUT_CYCLES(2000)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .rx    (ifc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         pulses = 0;
    logic [7:0] cap_byte;
    logic [1:0] cap_err;

    logic [7:0] m_byte;
    logic [1:0] m_err;

    always @(negedge clk) begin
        if (ifc.BYTE_READ) begin
            pulses   = pulses + 1;
            cap_byte = ifc.BYTE;
            cap_err  = ifc.BYTE_ERROR_CODE;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model: odd parity over 8 data bits + parity, stop must be 1.
    function automatic logic [1:0] model_err(input logic [7:0] d, input logic par, input logic stp);
        int ones;
        ones = $countones(d) + int'(par);
        return {(stp == 1'b0), (ones % 2 == 0)};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    // Device model: DATA changes mid-way through clock-high, then the clock falls.
    task automatic send_bits(input logic [10:0] bits, input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            #QTR_MCLK ifc.DATA_MOUSE_IN = bits[i];
            #QTR_MCLK ifc.CLK_MOUSE_IN  = 1'b0;
            #HALF_MCLK ifc.CLK_MOUSE_IN = 1'b1;
            if (i == drop_at) ifc.READ_ENABLE = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                             input logic stp, input bit exp_pulse, input int drop_at);
        int p0;
        p0 = pulses;
        send_bits(mk_frame(d, par, stp), 11, drop_at);
        repeat (10) @(negedge clk);
        chk({tag, "_pulses"}, pulses - p0, {31'd0, exp_pulse});
        if (exp_pulse) begin
            m_byte = d;
            m_err  = model_err(d, par, stp);
            chk({tag, "_strobe_byte"}, cap_byte, m_byte);
            chk({tag, "_strobe_err"},  cap_err,  m_err);
        end
        chk({tag, "_byte"},  ifc.BYTE, m_byte);
        chk({tag, "_err"},   ifc.BYTE_ERROR_CODE, m_err);
        chk({tag, "_state"}, ifc.STATE, 3'd0);
    endtask

    initial begin
        int p0;
        logic [7:0] rd;
        logic rp, rs;

        rst_n             = 1'b1;
        ifc.CLK_MOUSE_IN  = 1'b1;
        ifc.DATA_MOUSE_IN = 1'b1;
        ifc.READ_ENABLE   = 1'b1;
        m_byte = 8'h00;
        m_err  = 2'b00;

        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", ifc.STATE, 3'd0);
        chk("rst_byte",  ifc.BYTE, 8'h00);
        chk("rst_err",   ifc.BYTE_ERROR_CODE, 2'b00);
        chk("rst_strobe", ifc.BYTE_READ, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frame, then parity and stop errors
        run_frame("t1_5a", 8'h5A, 1'b1, 1'b1, 1'b1, -1);
        run_frame("t2_fa_par", 8'hFA, 1'b0, 1'b1, 1'b1, -1);
        run_frame("t2_00_stop", 8'h00, 1'b1, 1'b0, 1'b1, -1);

        // Truncated frame abandoned by timeout
        p0 = pulses;
        send_bits(mk_frame(8'h35, 1'b1, 1'b1), 5, -1);
        repeat (100) @(negedge clk);
        chk("t3_mid_state", ifc.STATE, 3'd1);
        repeat (2010) @(negedge clk);
        chk("t3_to_state",  ifc.STATE, 3'd0);
        chk("t3_to_pulses", pulses - p0, 0);
        chk("t3_to_byte",   ifc.BYTE, m_byte);
        run_frame("t3_08", 8'h08, 1'b0, 1'b1, 1'b1, -1);

        // READ_ENABLE low for a whole frame, then dropped mid-frame
        ifc.READ_ENABLE = 1'b0;
        run_frame("t4_11_dis", 8'h11, good_par(8'h11), 1'b1, 1'b0, -1);
        ifc.READ_ENABLE = 1'b1;
        run_frame("t4_22_drop", 8'h22, good_par(8'h22), 1'b1, 1'b1, 4);
        ifc.READ_ENABLE = 1'b1;

        // Asynchronous reset during data bit 5
        p0 = pulses;
        send_bits(mk_frame(8'h6C, good_par(8'h6C), 1'b1), 6, -1);
        repeat (5) @(negedge clk);
        chk("t5_pre_state", ifc.STATE, 3'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_state", ifc.STATE, 3'd0);
        chk("t5_async_byte",  ifc.BYTE, 8'h00);
        chk("t5_async_err",   ifc.BYTE_ERROR_CODE, 2'b00);
        #99 rst_n = 1'b1;
        m_byte = 8'h00;
        m_err  = 2'b00;
        repeat (20) @(negedge clk);
        chk("t5_pulses", pulses - p0, 0);
        run_frame("t5_aa", 8'hAA, good_par(8'hAA), 1'b1, 1'b1, -1);

        // Glitch edge with DATA high in IDLE, then back-to-back frames
        p0 = pulses;
        send_bits(11'h7FF, 1, -1);
        repeat (10) @(negedge clk);
        chk("t6_glitch_state",  ifc.STATE, 3'd0);
        chk("t6_glitch_pulses", pulses - p0, 0);
        run_frame("t6_08", 8'h08, good_par(8'h08), 1'b1, 1'b1, -1);
        run_frame("t6_01", 8'h01, good_par(8'h01), 1'b1, 1'b1, -1);
        run_frame("t6_ff", 8'hFF, good_par(8'hFF), 1'b1, 1'b1, -1);

        // Randomised frames with occasional parity/stop corruption
        for (int k = 0; k < 12; k++) begin
            rd = 8'($urandom_range(0, 255));
            rp = good_par(rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 5) != 0);
            run_frame($sformatf("rnd%0d", k), rd, rp, rs, 1'b1, -1);
            repeat ($urandom_range(5, 60)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
